nr_converge: RTL and testbench

NR_CONVERGE -- requirements
Module: nr_converge

---
 rtl/nr_pkg.sv | 27 ++
 rtl/f32_ulp_dist.sv | 28 ++
 rtl/nr_converge.sv | 132 +++++++++++++
 tb/tb_nr_converge.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/nr_pkg.sv
// Shared definitions for the Newton-Raphson convergence monitor.
// Holds IEEE-754 single field widths, field masks, the canonical qNaN
// and the monitor FSM state encoding.
package nr_pkg;

  localparam int F32_W = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [F32_W-1:0] F32_EXP_MASK = 32'h7F80_0000;
  localparam logic [F32_W-1:0] F32_MAN_MASK = 32'h007F_FFFF;
  localparam logic [F32_W-1:0] F32_QNAN     = 32'hFFC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FIRST = 3'd1,
    ST_WAIT_NEXT  = 3'd2,
    ST_COMPARE    = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  // NaN: exponent all ones and a non-zero mantissa.
  function automatic logic f32_is_nan(input logic [F32_W-1:0] f);
    return ((f & F32_EXP_MASK) == F32_EXP_MASK) && ((f & F32_MAN_MASK) != '0);
  endfunction

endpackage

// File: rtl/f32_ulp_dist.sv
// ULP distance between two IEEE-754 singles, saturated to 32 bits.
// Latency: combinational.
// Backpressure: none.
import nr_pkg::*;

module f32_ulp_dist (
  input  logic [F32_W-1:0] i_a,
  input  logic [F32_W-1:0] i_b,
  output logic [31:0]      o_dist
);

  // Sign-magnitude mapped onto a signed 33-bit key, so +0 and -0 both
  // land on key 0 and infinities are just the largest magnitudes.
  logic [32:0] w_key_a;
  logic [32:0] w_key_b;
  logic [33:0] w_diff;
  logic [33:0] w_abs;

  // Key formation, signed difference, magnitude and saturation.
  always_comb begin
    w_key_a = i_a[31] ? (33'd0 - {2'b00, i_a[30:0]}) : {2'b00, i_a[30:0]};
    w_key_b = i_b[31] ? (33'd0 - {2'b00, i_b[30:0]}) : {2'b00, i_b[30:0]};
    w_diff  = {w_key_a[32], w_key_a} - {w_key_b[32], w_key_b};
    w_abs   = w_diff[33] ? (34'd0 - w_diff) : w_diff;
    o_dist  = (w_abs[33:32] != 2'b00) ? 32'hFFFF_FFFF : w_abs[31:0];
  end

endmodule

// File: rtl/nr_converge.sv
// Watches iterates from an upstream divider and stops when two consecutive
// iterates are within TOL_ULP, or after MAX_ITER iterates.
// Latency: done rises 2 edges after the edge that accepts the final iterate.
// Backpressure: none; strobe edges arriving in IDLE, COMPARE or DONE are dropped.
// Optional: define NR_NAN_ABORT_EN to abort the run on a NaN iterate.
import nr_pkg::*;

module nr_converge #(
  parameter int MAX_ITER = 32,
  parameter int TOL_ULP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [F32_W-1:0] input_z,
  input  logic             input_z_stb,
  output logic [F32_W-1:0] result,
  output logic [5:0]       iter_count,
  output logic             busy,
  output logic             done,
  output logic             converged
);

  localparam logic [31:0] TOL_W = 32'(TOL_ULP);
  localparam logic [5:0]  MAX_W = 6'(MAX_ITER);

  state_t           r_state;
  state_t           w_next;
  logic             r_stb_prev;
  logic [F32_W-1:0] r_cur;
  logic [F32_W-1:0] r_prev;
  logic [F32_W-1:0] r_result;
  logic [5:0]       r_iter;
  logic             r_done;
  logic             r_conv;

  logic             w_stb_edge;
  logic             w_accept;
  logic [31:0]      w_dist;
  logic             w_hit_tol;
  logic             w_hit_max;

  f32_ulp_dist u_dist (
    .i_a    (r_prev),
    .i_b    (r_cur),
    .o_dist (w_dist)
  );

  assign w_stb_edge = input_z_stb & ~r_stb_prev;
  assign w_hit_tol  = (w_dist <= TOL_W);
  assign w_hit_max  = (r_iter == MAX_W);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; start overrides everything and swallows a coincident strobe.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    if (start) begin
      w_next = ST_WAIT_FIRST;
    end else begin
      case (r_state)
        ST_WAIT_FIRST: begin
          if (w_stb_edge) begin
            w_accept = 1'b1;
            w_next   = ST_WAIT_NEXT;
`ifdef NR_NAN_ABORT_EN
            if (f32_is_nan(input_z)) w_next = ST_DONE;
`endif
          end
        end
        ST_WAIT_NEXT: begin
          if (w_stb_edge) begin
            w_accept = 1'b1;
            w_next   = ST_COMPARE;
`ifdef NR_NAN_ABORT_EN
            if (f32_is_nan(input_z)) w_next = ST_DONE;
`endif
          end
        end
        ST_COMPARE: begin
          if (w_hit_tol || w_hit_max) w_next = ST_DONE;
          else                        w_next = ST_WAIT_NEXT;
        end
        default: w_next = r_state;
      endcase
    end
  end

  // Iterate history, counters and the registered done/converged flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stb_prev <= 1'b0;
      r_cur      <= '0;
      r_prev     <= '0;
      r_result   <= '0;
      r_iter     <= '0;
      r_done     <= 1'b0;
      r_conv     <= 1'b0;
    end else begin
      r_stb_prev <= input_z_stb;
      if (start) begin
        r_cur  <= '0;
        r_prev <= '0;
        r_iter <= '0;
        r_done <= 1'b0;
        r_conv <= 1'b0;
      end else begin
        if (w_accept) begin
          r_prev   <= r_cur;
          r_cur    <= input_z;
          r_result <= input_z;
          r_iter   <= (r_state == ST_WAIT_FIRST) ? 6'd1 : r_iter + 6'd1;
        end
        if (r_state == ST_COMPARE && w_hit_tol) r_conv <= 1'b1;
        if (r_state == ST_DONE)                 r_done <= 1'b1;
      end
    end
  end

  assign result     = r_result;
  assign iter_count = r_iter;
  assign busy       = (r_state == ST_WAIT_FIRST) || (r_state == ST_WAIT_NEXT) ||
                      (r_state == ST_COMPARE);
  assign done       = r_done;
  assign converged  = r_done & r_conv;

endmodule

// File: tb/tb_nr_converge.sv
// Directed self-checking bench for nr_converge (MAX_ITER=4, TOL_ULP=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Define NR_NAN_ABORT_EN to also exercise the NaN abort path.
module tb_nr_converge;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] input_z;
  logic        input_z_stb;
  logic [31:0] result;
  logic [5:0]  iter_count;
  logic        busy;
  logic        done;
  logic        converged;

  int n_checks = 0;
  int n_errors = 0;

  nr_converge #(.MAX_ITER(4), .TOL_ULP(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .input_z     (input_z),
    .input_z_stb (input_z_stb),
    .result      (result),
    .iter_count  (iter_count),
    .busy        (busy),
    .done        (done),
    .converged   (converged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One-cycle strobe then one idle cycle: accept edge E0, then edge E1.
  task automatic send(input logic [31:0] v);
    input_z     = v;
    input_z_stb = 1'b1;
    tick();
    input_z_stb = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; input_z = '0; input_z_stb = 1'b0;
    tick(); tick();
    check("rst_result", result, 32'h0);
    check("rst_iter",   {26'd0, iter_count}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_conv",   {31'd0, converged}, 32'd0);
    #2 rst = 1'b0;
    tick();

    // IDLE ignores strobes.
    send(32'h3F80_0000);
    check("idle_iter", {26'd0, iter_count}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Convergence within 3 ULP; done rises on the second edge after acceptance.
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    send(32'h3F80_0000);
    check("first_iter", {26'd0, iter_count}, 32'd1);
    send(32'h3F80_0003);
    check("conv_done_e1", {31'd0, done}, 32'd0);
    tick();
    check("conv_done",   {31'd0, done}, 32'd1);
    check("conv_conv",   {31'd0, converged}, 32'd1);
    check("conv_iter",   {26'd0, iter_count}, 32'd2);
    check("conv_result", result, 32'h3F80_0003);
    check("conv_busy",   {31'd0, busy}, 32'd0);
    // DONE holds and ignores strobes.
    send(32'h4000_0000);
    check("hold_result", result, 32'h3F80_0003);
    check("hold_iter",   {26'd0, iter_count}, 32'd2);
    check("hold_done",   {31'd0, done}, 32'd1);

    // Tolerance boundary: 5 ULP keeps going, exactly 4 ULP converges.
    pulse_start();
    check("restart_done", {31'd0, done}, 32'd0);
    send(32'h3F80_0000);
    send(32'h3F80_0005);
    check("tol5_busy", {31'd0, busy}, 32'd1);
    send(32'h3F80_0009);
    tick();
    check("tol4_done", {31'd0, done}, 32'd1);
    check("tol4_conv", {31'd0, converged}, 32'd1);
    check("tol4_iter", {26'd0, iter_count}, 32'd3);

    // 16 ULP steps never converge; MAX_ITER=4 forces the stop.
    pulse_start();
    send(32'h3F80_0000);
    send(32'h3F80_0010);
    send(32'h3F80_0020);
    check("max3_busy", {31'd0, busy}, 32'd1);
    check("max3_done", {31'd0, done}, 32'd0);
    send(32'h3F80_0030);
    tick();
    check("max_done",   {31'd0, done}, 32'd1);
    check("max_conv",   {31'd0, converged}, 32'd0);
    check("max_iter",   {26'd0, iter_count}, 32'd4);
    check("max_result", result, 32'h3F80_0030);

    // +0 and -0 are the same point.
    pulse_start();
    send(32'h0000_0000);
    send(32'h8000_0000);
    tick();
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_conv", {31'd0, converged}, 32'd1);

    // +1.0 vs -1.0 is far apart: still running.
    pulse_start();
    send(32'h3F80_0000);
    send(32'hBF80_0000);
    tick();
    check("pm1_done", {31'd0, done}, 32'd0);
    check("pm1_busy", {31'd0, busy}, 32'd1);
    check("pm1_iter", {26'd0, iter_count}, 32'd2);

    // Strobe held high 5 cycles counts once (start also restarts a live run).
    pulse_start();
    input_z = 32'h4000_0000;
    input_z_stb = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    input_z_stb = 1'b0;
    tick();
    check("held_iter",   {26'd0, iter_count}, 32'd1);
    check("held_result", result, 32'h4000_0000);

    // Strobe edge coincident with start is dropped.
    start = 1'b1; input_z = 32'h4040_0000; input_z_stb = 1'b1;
    tick();
    start = 1'b0;
    tick();
    input_z_stb = 1'b0;
    tick();
    check("coinc_iter", {26'd0, iter_count}, 32'd0);
    check("coinc_busy", {31'd0, busy}, 32'd1);

    // Asynchronous reset mid-COMPARE clears everything at once.
    send(32'h3F80_0000);
    input_z = 32'h3F80_0001; input_z_stb = 1'b1;
    tick();
    check("cmp_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_result", result, 32'h0);
    check("arst_iter",   {26'd0, iter_count}, 32'd0);
    check("arst_busy",   {31'd0, busy}, 32'd0);
    check("arst_done",   {31'd0, done}, 32'd0);
    check("arst_conv",   {31'd0, converged}, 32'd0);
    #2 rst = 1'b0; input_z_stb = 1'b0;
    tick(); tick(); tick();
    check("arst_nodone", {31'd0, done}, 32'd0);
    check("arst_idle",   {31'd0, busy}, 32'd0);

`ifdef NR_NAN_ABORT_EN
    // NaN iterate aborts the run directly.
    pulse_start();
    send(32'h3F80_0000);
    send(32'h7FC0_0000);
    check("nan_done",   {31'd0, done}, 32'd1);
    check("nan_conv",   {31'd0, converged}, 32'd0);
    check("nan_result", result, 32'h7FC0_0000);
    check("nan_iter",   {26'd0, iter_count}, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
